// File: rtl/ieee_sd_arbiter.sv
// Round-robin arbiter funnelling per-device SD block requests onto one host
// SD channel. The winner's LBA, block count and operation are latched for the
// whole transfer; host ack and write data are routed to/from that device only.
// A request that the host never acks is aborted after TIMEOUT cycles.
module ieee_sd_arbiter #(
  parameter int unsigned NBD     = 2,
  parameter logic [23:0] TIMEOUT = 24'd16_000_000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [32*NBD-1:0] dev_lba,
  input  logic [6*NBD-1:0]  dev_blk_cnt,
  input  logic [NBD-1:0]    dev_rd,
  input  logic [NBD-1:0]    dev_wr,
  output logic [NBD-1:0]    dev_ack,
  input  logic [8*NBD-1:0]  dev_buff_din,
  output logic [31:0]       sd_lba,
  output logic [5:0]        sd_blk_cnt,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic [7:0]        sd_buff_din,
  output logic [2:0]        sd_dev,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t          state, state_nx;
  logic [NBD-1:0]  rd_q, wr_q;
  logic [2:0]      ptr;
  logic [23:0]     tmo_cnt;

  logic            hi_vld, lo_vld, win_vld;
  logic [2:0]      hi_idx, lo_idx, win_idx;
  logic [31:0]     sel_lba;
  logic [5:0]      sel_cnt;
  logic            sel_wr;
  logic [NBD-1:0]  ack_nx;

  logic            do_grant, do_ack, do_tmo, do_done;

  // Round-robin search: first pending index at or above the pointer,
  // otherwise the first pending index below it (wrap-around).
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int unsigned i = 0; i < NBD; i++) begin
      if (!hi_vld && (rd_q[i] || wr_q[i]) && (3'(i) >= ptr)) begin
        hi_vld = 1'b1;
        hi_idx = 3'(i);
      end
      if (!lo_vld && (rd_q[i] || wr_q[i])) begin
        lo_vld = 1'b1;
        lo_idx = 3'(i);
      end
    end
    win_vld = hi_vld || lo_vld;
    win_idx = hi_vld ? hi_idx : lo_idx;
  end

  // Fetch the winner's LBA, block count and operation (write has priority).
  always_comb begin
    sel_lba = '0;
    sel_cnt = '0;
    sel_wr  = 1'b0;
    for (int unsigned i = 0; i < NBD; i++) begin
      if (win_idx == 3'(i)) begin
        sel_lba = dev_lba[32*i +: 32];
        sel_cnt = dev_blk_cnt[6*i +: 6];
        sel_wr  = wr_q[i];
      end
    end
  end

  // Write data from the granted device, only while the transfer runs.
  always_comb begin
    sd_buff_din = '0;
    for (int unsigned i = 0; i < NBD; i++) begin
      if (state == XFER && sd_dev == 3'(i)) sd_buff_din = dev_buff_din[8*i +: 8];
    end
  end

  // Host ack steered to the granted device; ignored in IDLE/DONE.
  always_comb begin
    ack_nx = '0;
    for (int unsigned i = 0; i < NBD; i++) begin
      ack_nx[i] = sd_ack && (state == REQ || state == XFER) && (sd_dev == 3'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM next state and per-transition strobes.
  always_comb begin
    state_nx = state;
    do_grant = 1'b0;
    do_ack   = 1'b0;
    do_tmo   = 1'b0;
    do_done  = 1'b0;
    case (state)
      IDLE: if (win_vld) begin
        state_nx = REQ;
        do_grant = 1'b1;
      end
      REQ: begin
        if (sd_ack) begin
          state_nx = XFER;
          do_ack   = 1'b1;
        end else if (tmo_cnt == TIMEOUT - 24'd1) begin
          state_nx = DONE;
          do_tmo   = 1'b1;
        end
      end
      XFER: if (!sd_ack) state_nx = DONE;
      DONE: begin
        state_nx = IDLE;
        do_done  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request sampling stage (gives the two-clock grant latency), latched
  // transfer parameters, timeout counter and round-robin pointer.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_q        <= '0;
      wr_q        <= '0;
      ptr         <= '0;
      tmo_cnt     <= '0;
      sd_dev      <= '0;
      sd_lba      <= '0;
      sd_blk_cnt  <= '0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      timeout_err <= 1'b0;
      dev_ack     <= '0;
    end else begin
      rd_q        <= dev_rd;
      wr_q        <= dev_wr;
      timeout_err <= do_tmo;
      dev_ack     <= ack_nx;
      if (do_grant) begin
        sd_dev     <= win_idx;
        sd_lba     <= sel_lba;
        sd_blk_cnt <= sel_cnt;
        sd_wr      <= sel_wr;
        sd_rd      <= !sel_wr;
        tmo_cnt    <= '0;
      end else if (state == REQ) begin
        tmo_cnt <= tmo_cnt + 24'd1;
      end
      if (do_ack || do_tmo) begin
        sd_rd <= 1'b0;
        sd_wr <= 1'b0;
      end
      if (do_done) ptr <= (sd_dev == 3'(NBD - 1)) ? 3'd0 : sd_dev + 3'd1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ieee_sd_arbiter.sv
// Directed bench for ieee_sd_arbiter: a cycle-stepped host/device model
// drives stimulus, expected grants go into a scoreboard queue, and a
// separate monitor pops and checks each grant and its transfer.
module tb_ieee_sd_arbiter;
  localparam int unsigned NBD = 2;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b1;
  logic [32*NBD-1:0] dev_lba;
  logic [6*NBD-1:0]  dev_blk_cnt;
  logic [NBD-1:0]    dev_rd, dev_wr, dev_ack;
  logic [8*NBD-1:0]  dev_buff_din;
  logic [31:0]       sd_lba;
  logic [5:0]        sd_blk_cnt;
  logic              sd_rd, sd_wr, sd_ack;
  logic [7:0]        sd_buff_din;
  logic [2:0]        sd_dev;
  logic              busy, timeout_err;

  always #5 clk_sys = ~clk_sys;

  ieee_sd_arbiter #(.NBD(NBD), .TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .dev_lba(dev_lba), .dev_blk_cnt(dev_blk_cnt),
    .dev_rd(dev_rd), .dev_wr(dev_wr), .dev_ack(dev_ack),
    .dev_buff_din(dev_buff_din),
    .sd_lba(sd_lba), .sd_blk_cnt(sd_blk_cnt),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din), .sd_dev(sd_dev),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    bit          wr;
    int          dev;
    logic [31:0] lba;
    logic [5:0]  cnt;
    int          ack_len;
    logic [7:0]  buff;
    int          tmo;
    bit          abort;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   cur_active = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   stray  = 0;

  // host model
  bit             host_en = 1'b0;
  int             host_st = 0, host_cnt = 0, host_delay = 0, host_len = 0;
  logic [NBD-1:0] ack_prev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit wr, input int dev, input logic [31:0] lba, input logic [5:0] cnt,
                      input int ack_len, input logic [7:0] buff, input int tmo, input bit abort);
    exp_t e;
    e.wr = wr; e.dev = dev; e.lba = lba; e.cnt = cnt;
    e.ack_len = ack_len; e.buff = buff; e.tmo = tmo; e.abort = abort;
    sb.push_back(e);
  endtask

  // One clock: devices drop the op being served on the rising edge of their
  // ack (write first), and the host model acks a pending request.
  task automatic step();
    @(negedge clk_sys);
    for (int unsigned i = 0; i < NBD; i++) begin
      if (dev_ack[i] && !ack_prev[i]) begin
        if (dev_wr[i]) dev_wr[i] = 1'b0;
        else           dev_rd[i] = 1'b0;
      end
    end
    ack_prev = dev_ack;
    if (host_en) begin
      case (host_st)
        0: if (sd_rd || sd_wr) begin
          if (host_delay == 0) begin sd_ack = 1'b1; host_cnt = host_len; host_st = 2; end
          else begin host_cnt = host_delay; host_st = 1; end
        end
        1: begin
          host_cnt--;
          if (host_cnt == 0) begin sd_ack = 1'b1; host_cnt = host_len; host_st = 2; end
        end
        2: begin
          host_cnt--;
          if (host_cnt == 0) begin sd_ack = 1'b0; host_st = 0; end
        end
        default: host_st = 0;
      endcase
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy || cur_active) && n < 3000) begin
      step();
      n++;
    end
    chk({name, "_budget"}, 64'(n >= 3000), 0);
    repeat (2) step();
  endtask

  // Monitor: pops the scoreboard on each new host request and checks the
  // whole transfer when busy falls.
  initial begin
    logic           req_prev = 1'b0, busy_prev = 1'b0;
    int             ack_cnt = 0, tmo_cnt = 0;
    bit             ack_bad = 1'b0, route_bad = 1'b0;
    logic [NBD-1:0] oh;
    forever begin
      @(posedge clk_sys);
      #2;
      if ((sd_rd || sd_wr) && !req_prev) begin
        chk("sb_has_entry", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          chk("grant_op",  {sd_wr, sd_rd}, cur.wr ? 2'b10 : 2'b01);
          chk("grant_dev", sd_dev, 3'(cur.dev));
          chk("grant_lba", sd_lba, cur.lba);
          chk("grant_cnt", sd_blk_cnt, cur.cnt);
          cur_active = 1'b1;
          ack_cnt = 0; tmo_cnt = 0; ack_bad = 1'b0; route_bad = 1'b0;
        end
      end
      if (dev_ack != '0) begin
        if (cur_active) begin
          oh = '0;
          oh[cur.dev] = 1'b1;
          ack_cnt++;
          if (dev_ack != oh) ack_bad = 1'b1;
          if (sd_buff_din != cur.buff) route_bad = 1'b1;
        end else begin
          stray++;
        end
      end
      if (cur_active && timeout_err) tmo_cnt++;
      if (busy_prev && !busy && cur_active) begin
        if (!cur.abort) begin
          chk("xfer_ack_cycles", ack_cnt, cur.ack_len);
          chk("xfer_ack_onehot", ack_bad, 0);
          chk("xfer_buff_route", route_bad, 0);
          chk("xfer_timeout_pulses", tmo_cnt, cur.tmo);
        end
        cur_active = 1'b0;
      end
      req_prev  = sd_rd || sd_wr;
      busy_prev = busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    dev_lba = '0; dev_blk_cnt = '0; dev_rd = '0; dev_wr = '0;
    dev_buff_din = {8'h55, 8'hAA};
    sd_ack = 1'b0;
    #2 reset_n = 1'b0;
    #21;
    chk("reset_outs", {sd_rd, sd_wr, busy, timeout_err, sd_dev, sd_lba, sd_blk_cnt, sd_buff_din, dev_ack}, 0);
    step();
    reset_n = 1'b1;
    step();

    // single read on device 0, two-clock grant latency, 256-cycle ack
    host_en = 1'b1; host_delay = 3; host_len = 256;
    push(0, 0, 32'h12, 6'd0, 256, 8'hAA, 0, 0);
    dev_lba[31:0] = 32'h12; dev_blk_cnt[5:0] = 6'd0; dev_rd[0] = 1'b1;
    step();
    chk("lat1_sd_rd", sd_rd, 0);
    step();
    chk("lat2_sd_rd", sd_rd, 1);
    chk("lat2_sd_lba", sd_lba, 32'h12);
    wait_done("single");
    chk("single_idle", busy, 0);

    // device 1 read: write data must come from device 1
    host_delay = 0; host_len = 8;
    push(0, 1, 32'h34, 6'd2, 8, 8'h55, 0, 0);
    dev_lba[63:32] = 32'h34; dev_blk_cnt[11:6] = 6'd2; dev_rd[1] = 1'b1;
    wait_done("route");

    // contention with pointer at 0: dev0 write then dev1 read
    host_delay = 1; host_len = 4;
    push(1, 0, 32'h100, 6'd5, 4, 8'hAA, 0, 0);
    push(0, 1, 32'h200, 6'd63, 4, 8'h55, 0, 0);
    dev_lba = {32'h200, 32'h100}; dev_blk_cnt = {6'd63, 6'd5};
    dev_wr[0] = 1'b1; dev_rd[1] = 1'b1;
    wait_done("contend");

    // dev0 re-requests immediately while dev1 waits: grants alternate
    push(0, 0, 32'h300, 6'd7, 4, 8'hAA, 0, 0);
    push(1, 1, 32'h400, 6'd8, 4, 8'h55, 0, 0);
    push(0, 0, 32'h500, 6'd7, 4, 8'hAA, 0, 0);
    dev_lba = {32'h400, 32'h300}; dev_blk_cnt = {6'd8, 6'd7};
    dev_rd[0] = 1'b1; dev_wr[1] = 1'b1;
    n = 0;
    while (!dev_ack[0] && n < 100) begin step(); n++; end
    chk("rr_reach_ack", dev_ack[0], 1);
    dev_rd[0] = 1'b1; dev_lba[31:0] = 32'h500;
    wait_done("rr");

    // same device rd+wr: write first, then read with same LBA
    push(1, 1, 32'h777, 6'd1, 4, 8'h55, 0, 0);
    push(0, 1, 32'h777, 6'd1, 4, 8'h55, 0, 0);
    dev_lba[63:32] = 32'h777; dev_blk_cnt[11:6] = 6'd1;
    dev_rd[1] = 1'b1; dev_wr[1] = 1'b1;
    wait_done("rdwr");

    // timeout: host never acks
    host_en = 1'b0; sd_ack = 1'b0;
    push(0, 0, 32'h9, 6'd0, 0, 8'h00, 1, 0);
    dev_lba[31:0] = 32'h9; dev_blk_cnt[5:0] = 6'd0; dev_rd[0] = 1'b1;
    n = 0;
    while (!sd_rd && n < 20) begin step(); n++; end
    n = 0;
    while (sd_rd && n < 300) begin
      n++;
      if (n == 50) dev_lba[31:0] = 32'hDEAD_BEEF;
      if (n == 60) chk("tmo_lba_stable", sd_lba, 32'h9);
      step();
    end
    chk("tmo_req_cycles", n, 100);
    chk("tmo_pulse", timeout_err, 1);
    dev_rd[0] = 1'b0;
    step();
    chk("tmo_pulse_once", timeout_err, 0);
    chk("tmo_back_idle", busy, 0);
    sd_ack = 1'b1;
    repeat (3) begin
      step();
      chk("spurious_no_ack", dev_ack, 0);
      chk("spurious_no_busy", busy, 0);
    end
    sd_ack = 1'b0;
    wait_done("tmo");

    // reset mid-transfer with sd_ack high; pointer (now 1) must return to 0
    host_en = 1'b1; host_delay = 0; host_len = 50;
    push(0, 1, 32'h55AA, 6'd0, 50, 8'h55, 0, 1);
    dev_lba[63:32] = 32'h55AA; dev_blk_cnt[11:6] = 6'd0; dev_rd[1] = 1'b1;
    n = 0;
    while (!dev_ack[1] && n < 100) begin step(); n++; end
    chk("rst_reach_xfer", dev_ack[1], 1);
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_outs", {sd_rd, sd_wr, busy, timeout_err, sd_dev, sd_lba, sd_blk_cnt, sd_buff_din, dev_ack}, 0);
    host_st = 0; sd_ack = 1'b0; ack_prev = '0; dev_rd = '0; dev_wr = '0;
    host_delay = 1; host_len = 6;
    push(1, 0, 32'h66, 6'd3, 6, 8'hAA, 0, 0);
    push(0, 1, 32'h77, 6'd4, 6, 8'h55, 0, 0);
    dev_lba = {32'h77, 32'h66}; dev_blk_cnt = {6'd4, 6'd3};
    dev_wr[0] = 1'b1; dev_rd[1] = 1'b1;
    step();
    reset_n = 1'b1;
    chk("rst_release_idle", busy, 0);
    wait_done("after_rst");

    chk("stray_ack_cycles", stray, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
